// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
//
// Shared definitions for the sequential adder/subtractor (addsub_seq):
//   - state_t     : controller states (IDLE / RUN / DONE)
//   - MODE_ADD/SUB: encoding of the 'sub' operation select input
//   - sat_limit() : signed max / min pattern for a given width, used when the
//                   saturating build (ADDSUB_SAT_EN) is selected.
// -----------------------------------------------------------------------------
package addsub_pkg;

  // Controller state. The encoding is visible on the top-level debug port,
  // so keep it fixed.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operation select encoding on the 'sub' input.
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Signed limit for a w-bit two's-complement value, returned in the low w
  // bits of a 64-bit word (callers slice it down to their width).
  //   neg = 0 -> most positive value {0,1..1}
  //   neg = 1 -> most negative value {1,0..0}
  function automatic logic [63:0] sat_limit(input int unsigned w, input logic neg);
    logic [63:0] half;
    half = 64'd1 << (w - 1);
    return neg ? half : (half - 64'd1);
  endfunction

endpackage : addsub_pkg

// File: rtl/addsub_chunk.sv
// -----------------------------------------------------------------------------
// addsub_chunk
//
// Purely combinational CHUNK-bit ripple of full adders. One instance is reused
// every clock by addsub_seq to process one slice of the operands.
//
// Parameters:
//   CHUNK  : slice width in bits (>= 1)
//
// Ports:
//   x, y   in  CHUNK  slice operands (y is already inverted for subtraction)
//   ci     in  1      carry into bit 0 of the slice
//   sum    out CHUNK  slice sum
//   co     out 1      carry out of the top bit of the slice
//   c_msb  out 1      carry into the top bit of the slice; on the last slice
//                     this is the carry into the operand MSB, needed for the
//                     signed-overflow flag
// -----------------------------------------------------------------------------
module addsub_chunk #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] sum,
  output logic             co,
  output logic             c_msb
);

  // c[i] is the carry into bit i; c[CHUNK] is the carry out of the slice.
  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = x[i] ^ y[i] ^ c[i];
      c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule : addsub_chunk

// File: rtl/addsub_seq.sv
// -----------------------------------------------------------------------------
// addsub_seq
//
// Multi-cycle WIDTH-bit adder/subtractor. Operands are captured once, then
// processed CHUNK bits per clock through a single addsub_chunk slice with the
// carry held in a register between slices. Produces carry-out and a signed
// overflow flag, with valid/ready handshakes on both sides.
//
//   add : {Cout, s} = a + b + Cin
//   sub : {Cout, s} = a + ~b + ~Cin   (= a - b - Cin; Cout = 1 means no borrow)
//   ovf = carry into MSB ^ carry out of MSB
//
// Handshakes (both sides): a transfer happens on a rising edge where valid
// and ready are both 1. Valid must not depend on ready. On the input side
// in_ready = IDLE | (DONE & out_ready), so in_ready has a combinational path
// from out_ready; this lets a new operation be accepted on the same edge the
// previous result is consumed. On the output side out_valid = (state == DONE)
// and s / Cout / ovf are held stable until out_ready is seen.
//
// Parameters:
//   WIDTH : operand / result width
//   CHUNK : bits processed per clock; WIDTH must be a multiple of CHUNK
//
// Ports:
//   clk        in  1      clock, rising edge
//   rst        in  1      synchronous reset, active-high
//   in_valid   in  1      operands present
//   in_ready   out 1      operands can be accepted this cycle
//   a, b       in  WIDTH  operands
//   Cin        in  1      carry-in (add) / borrow-in (sub)
//   sub        in  1      MODE_ADD (0) / MODE_SUB (1)
//   out_valid  out 1      result valid
//   out_ready  in  1      consumer takes the result
//   s          out WIDTH  result (defined only while out_valid = 1)
//   Cout       out 1      carry-out
//   ovf        out 1      two's-complement overflow
//   state_dbg  out 2      current controller state (state_t encoding)
//
// Build option:
//   ADDSUB_SAT_EN : when defined, an overflowing result is clamped to the
//                   signed limit in the direction of the true result; Cout and
//                   ovf still report the raw values. When undefined, s is the
//                   wrapped result and no clamp logic exists.
//
// Latency: out_valid rises NCHUNK clocks after the accepting edge.
// -----------------------------------------------------------------------------
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             Cout,
  output logic             ovf,
  output logic [1:0]       state_dbg
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("addsub_seq: WIDTH must be a multiple of CHUNK");
  end

`ifdef ADDSUB_SAT_EN
  localparam logic [63:0] SAT_MAX_W = sat_limit(WIDTH, 1'b0);
  localparam logic [63:0] SAT_MIN_W = sat_limit(WIDTH, 1'b1);
  localparam logic [WIDTH-1:0] SAT_MAX = SAT_MAX_W[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SAT_MIN = SAT_MIN_W[WIDTH-1:0];
`endif

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  state_t state;
  state_t state_nx;

  logic [IDXW-1:0]  idx;       // slice currently being processed in RUN
  logic             accept;    // input handshake completes this edge
  logic             last;      // current slice is the final one

  assign accept = in_valid & in_ready;
  assign last   = (idx == IDX_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        // Consuming the result and accepting the next operation may happen
        // on the same edge, giving back-to-back operation with no bubble.
        if (out_ready) state_nx = in_valid ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] a_r;       // captured operand A
  logic [WIDTH-1:0] b_r;       // captured operand B, pre-inverted for sub
  logic             carry_r;   // carry between slices
  logic [WIDTH-1:0] s_r;
  logic             cout_r;
  logic             ovf_r;

  logic [CHUNK-1:0] ch_x;
  logic [CHUNK-1:0] ch_y;
  logic [CHUNK-1:0] ch_sum;
  logic             ch_co;
  logic             ch_msb;
  logic             fin_ovf;

  assign ch_x    = a_r[idx*CHUNK +: CHUNK];
  assign ch_y    = b_r[idx*CHUNK +: CHUNK];
  assign fin_ovf = ch_msb ^ ch_co;

  addsub_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .x     (ch_x),
    .y     (ch_y),
    .ci    (carry_r),
    .sum   (ch_sum),
    .co    (ch_co),
    .c_msb (ch_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      s_r     <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept) begin
      // Subtraction is folded into the operands here: B is inverted and the
      // borrow-in becomes a carry-in of ~Cin, so RUN only ever adds.
      a_r     <= a;
      b_r     <= (sub == MODE_SUB) ? ~b : b;
      carry_r <= Cin ^ (sub == MODE_SUB);
      idx     <= '0;
    end else if (state == RUN) begin
      s_r[idx*CHUNK +: CHUNK] <= ch_sum;
      carry_r                 <= ch_co;
      if (last) begin
        idx    <= '0;
        cout_r <= ch_co;
        ovf_r  <= fin_ovf;
`ifdef ADDSUB_SAT_EN
        // Overflow implies both effective operands share a sign, so the
        // sign of A gives the direction of the true result.
        if (fin_ovf) begin
          s_r <= a_r[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
`endif
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign s    = s_r;
  assign Cout = cout_r;
  assign ovf  = ovf_r;

endmodule : addsub_seq

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
Parametrised multi-cycle adder/subtractor; the sequential successor to the 1-bit/4-bit full-adder datapath.
- Processes a WIDTH-bit operand pair CHUNK bits per clock, rippling carry through a register.
- Adds a signed-overflow flag and valid/ready handshakes on both sides.
- Sits between an operand source and a result consumer in the arithmetic test datapath.

Parameters:
- WIDTH, 4: operand/result width in bits.
- CHUNK, 1: bits processed per cycle. WIDTH % CHUNK must be 0. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- Cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- s  out  WIDTH  result.
- Cout  out  1  carry-out; for sub, 1 = no borrow.
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Reset: one clock, synchronous, active-high; single clock domain. While rst is high at a rising edge: state=IDLE, chunk counter=0, s=0, Cout=0, ovf=0, out_valid=0. in_ready=1 from the following cycle.
- Arithmetic:
  - add: {Cout,s} = a + b + Cin.
  - sub: s = a + ~b + ~Cin, i.e. a - b - Cin. Cout = carry out of that sum.
  - ovf = carry into MSB XOR carry out of MSB, taken on the final chunk.
- Operand capture:
  - Accept on an edge with in_valid & in_ready.
  - a, sub, b (stored pre-inverted when sub=1) and initial carry (Cin, or ~Cin when sub=1) are latched.
  - Input changes after acceptance are ignored.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On accept: RUN, idx=0.
  - RUN: in_ready=0. Each edge computes chunk idx (bits idx*CHUNK +: CHUNK) and writes it into s; carry register is updated; idx++. When idx==NCHUNK-1: latch Cout and ovf, go to DONE.
  - DONE: out_valid=1; s, Cout and ovf stay stable while out_ready=0.
    - out_ready=1 and in_valid=0: go to IDLE.
    - out_ready=1 and in_valid=1: accept the new operation on the same edge, go to RUN (back-to-back, no bubble).
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is a combinational path from out_ready.
- Latency: out_valid rises exactly NCHUNK cycles after the accepting edge. Throughput: one result per NCHUNK cycles when out_ready is held at 1.
- s holds partial values during RUN; it is defined only while out_valid=1.
- Reset mid-RUN or mid-DONE: the operation is aborted, no out_valid is produced, and the result is lost.
- NCHUNK=1 (CHUNK==WIDTH): RUN lasts one cycle, so latency is 1.

Optional Feature:
Macro ADDSUB_SAT_EN.
- Defined: when ovf=1 on the final chunk, s is clamped to the signed limit: {0,1..1} if the true result is positive overflow (a sign 0), {1,0..0} if negative. ovf and Cout still report raw values.
- Undefined: s is the wrapped result, and no clamp logic is generated.

Decomposition:
- Package addsub_pkg: state enum (IDLE/RUN/DONE), MODE_ADD=0 / MODE_SUB=1 constants, and a function returning the signed max/min for a width.
- One sub-module, addsub_chunk: combinational CHUNK-bit ripple of full adders. Inputs: x, y, ci. Outputs: sum, co, and c_msb (carry into the top bit, used for ovf).

Test Plan:
1. WIDTH=4, CHUNK=1: add a=4'h7, b=4'h1, Cin=0 -> s=4'h8, Cout=0, ovf=1; out_valid exactly 4 cycles after accept.
2. WIDTH=4, CHUNK=1: sub a=4'h3, b=4'h5, Cin=0 -> s=4'hE, Cout=0 (borrow), ovf=0.
3. WIDTH=4, CHUNK=1: add a=4'hF, b=4'hF, Cin=1 -> s=4'hF, Cout=1, ovf=0.
4. Hold out_ready=0 for 10 cycles in DONE -> s, Cout, ovf stable and in_ready=0. Then out_ready=1 with in_valid=1 (a=4'h2, b=4'h2) -> accepted on that edge; next result s=4'h4 four cycles later.
5. Assert rst during RUN at idx=2 -> next cycle out_valid=0, in_ready=1, s=0; no result is ever emitted for the aborted operation.
6. WIDTH=8, CHUNK=4: add 8'h7F + 8'h01 -> latency 2, ovf=1. With ADDSUB_SAT_EN, s=8'h7F; without it, s=8'h80.
